pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/pipe_perf_cnt.sv | 30 +++
 rtl/pipe_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline controller state encoding, register-select and word types.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;
    typedef logic [1:0]  pipe_state_t;

    localparam pipe_state_t INIT  = 2'd0;
    localparam pipe_state_t RUN   = 2'd1;
    localparam pipe_state_t DWAIT = 2'd2;
    localparam pipe_state_t HALT  = 2'd3;

    localparam word_t WORD_MAX = 32'hFFFF_FFFF;

    // Load in EX writes a register that the instruction in ID reads; r0 never hazards.
    function automatic logic load_use_hazard(input logic ex_dren, input regbits_t ex_wsel,
                                             input regbits_t id_rs, input regbits_t id_rt);
        return ex_dren && (ex_wsel != 5'd0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating 32-bit event counter; only built when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  inc,
    output word_t count
);

    word_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != WORD_MAX))
            count_d = count_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard/stall controller. Optional performance counters
// (stall_cnt, flush_cnt) are added when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dren,
    input  logic        mem_dwen,
    input  logic        mem_halt,
    input  logic        ex_redirect,
    input  logic        ex_dren,
    input  regbits_t    ex_wsel,
    input  regbits_t    id_rs,
    input  regbits_t    id_rt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        halted,
`ifdef PIPE_CTRL_PERF_EN
    output word_t       stall_cnt,
    output word_t       flush_cnt,
`endif
    output pipe_state_t dbg_state
);

    pipe_state_t state_q, state_d;
    logic        dpend;
    logic        load_use;

    assign dpend    = (mem_dren | mem_dwen) & ~dhit;
    assign load_use = load_use_hazard(ex_dren, ex_wsel, id_rs, id_rt);

    // Rules are checked in priority order; a pending data access freezes everything.
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        case (state_q)
            INIT: begin
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
                state_d     = RUN;
            end
            RUN, DWAIT: begin
                if (dpend) begin
                    state_d = DWAIT;
                end else begin
                    state_d  = RUN;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    if (mem_halt) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        state_d     = HALT;
                    end else if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        pc_en      = 1'b1;
                    end else if (load_use) begin
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state_q <= INIT;
        else
            state_q <= state_d;
    end

    assign dbg_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic active;
    logic stall_inc;
    logic flush_inc;

    assign active    = (state_q == RUN) || (state_q == DWAIT);
    assign stall_inc = active && !pc_en;
    assign flush_inc = active && !dpend && !mem_halt && ex_redirect;

    pipe_perf_cnt u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_perf_cnt u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule
